// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I integer core: FETCH / EXEC / MEM / HALTED sequencing with
// pc/npc delay-slot handling and waitrequest-stalled instruction and data ports.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] instr_address,
   output logic        instr_read,
   input  logic [31:0] instr_readdata,
   input  logic        instr_waitrequest,
   output logic [31:0] data_address,
   output logic        data_read,
   output logic        data_write,
   output logic [31:0] data_writedata,
   input  logic [31:0] data_readdata,
   input  logic        data_waitrequest,
   output logic        active,
   output logic [31:0] register_v0
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_MEM    = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t      state_r, state_next_s;
   logic [31:0] pc_r, npc_r, ir_r;
   logic [31:0] regs_r [0:31];
   logic [31:0] data_address_r, data_writedata_r;
   logic        instr_read_r, data_read_r, data_write_r, active_r;

   logic [5:0]  opcode_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s;
   logic [31:0] sext_s, zext_s, rs_val_s, rt_val_s, pc_plus4_s;
   logic        alu_we_s, taken_s, is_load_s, is_store_s, is_mem_s;
   logic [4:0]  alu_waddr_s;
   logic [31:0] alu_wdata_s, target_s;
   logic        rf_we_s, advance_s;
   logic [4:0]  rf_waddr_s;
   logic [31:0] rf_wdata_s, npc_next_s;

   assign opcode_s   = ir_r[31:26];
   assign rs_s       = ir_r[25:21];
   assign rt_s       = ir_r[20:16];
   assign rd_s       = ir_r[15:11];
   assign funct_s    = ir_r[5:0];
   assign sext_s     = {{16{ir_r[15]}}, ir_r[15:0]};
   assign zext_s     = {16'd0, ir_r[15:0]};
   assign rs_val_s   = (rs_s == 5'd0) ? 32'd0 : regs_r[rs_s];
   assign rt_val_s   = (rt_s == 5'd0) ? 32'd0 : regs_r[rt_s];
   assign pc_plus4_s = pc_r + 32'd4;
   assign is_mem_s   = is_load_s | is_store_s;

   // Instruction decode, ALU result, branch resolution
   always_comb begin
      alu_we_s    = 1'b0;
      alu_waddr_s = rt_s;
      alu_wdata_s = 32'd0;
      taken_s     = 1'b0;
      target_s    = pc_plus4_s;
      is_load_s   = 1'b0;
      is_store_s  = 1'b0;
      case (opcode_s)
         6'h00: begin
            alu_waddr_s = rd_s;
            case (funct_s)
               6'h21: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s + rt_val_s; end
               6'h23: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s - rt_val_s; end
               6'h24: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s & rt_val_s; end
               6'h25: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s | rt_val_s; end
               6'h26: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s ^ rt_val_s; end
               6'h2A: begin alu_we_s = 1'b1; alu_wdata_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)}; end
               6'h2B: begin alu_we_s = 1'b1; alu_wdata_s = {31'd0, rs_val_s < rt_val_s}; end
               6'h08: begin taken_s = 1'b1; target_s = rs_val_s; end
               default: alu_we_s = 1'b0;
            endcase
         end
         6'h02: begin taken_s = 1'b1; target_s = {pc_plus4_s[31:28], ir_r[25:0], 2'b00}; end
         6'h03: begin
            taken_s     = 1'b1;
            target_s    = {pc_plus4_s[31:28], ir_r[25:0], 2'b00};
            alu_we_s    = 1'b1;
            alu_waddr_s = 5'd31;
            alu_wdata_s = pc_r + 32'd8;
         end
         6'h04: begin taken_s = (rs_val_s == rt_val_s); target_s = pc_plus4_s + {sext_s[29:0], 2'b00}; end
         6'h05: begin taken_s = (rs_val_s != rt_val_s); target_s = pc_plus4_s + {sext_s[29:0], 2'b00}; end
         6'h09: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s + sext_s; end
         6'h0C: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s & zext_s; end
         6'h0D: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s | zext_s; end
         6'h0E: begin alu_we_s = 1'b1; alu_wdata_s = rs_val_s ^ zext_s; end
         6'h0F: begin alu_we_s = 1'b1; alu_wdata_s = {ir_r[15:0], 16'd0}; end
         6'h23: is_load_s = 1'b1;
         6'h2B: is_store_s = 1'b1;
         default: alu_we_s = 1'b0;
      endcase
   end

   // Register-file write source and pc/npc advance
   always_comb begin
      rf_we_s    = 1'b0;
      rf_waddr_s = 5'd0;
      rf_wdata_s = 32'd0;
      advance_s  = 1'b0;
      npc_next_s = npc_r + 32'd4;
      if (state_r == ST_EXEC && !is_mem_s) begin
         rf_we_s    = alu_we_s;
         rf_waddr_s = alu_waddr_s;
         rf_wdata_s = alu_wdata_s;
         advance_s  = 1'b1;
         npc_next_s = taken_s ? target_s : (npc_r + 32'd4);
      end else if (state_r == ST_MEM && !data_waitrequest) begin
         rf_we_s    = is_load_s;
         rf_waddr_s = rt_s;
         rf_wdata_s = data_readdata;
         advance_s  = 1'b1;
      end else begin
         advance_s  = 1'b0;
      end
   end

   // Next-state logic; the halt test looks at the pc about to be loaded
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_FETCH: begin
            if (instr_waitrequest) state_next_s = ST_FETCH;
            else                   state_next_s = ST_EXEC;
         end
         ST_EXEC: begin
            if (is_mem_s)                    state_next_s = ST_MEM;
            else if (npc_r == HALT_ADDRESS)  state_next_s = ST_HALTED;
            else                             state_next_s = ST_FETCH;
         end
         ST_MEM: begin
            if (data_waitrequest)            state_next_s = ST_MEM;
            else if (npc_r == HALT_ADDRESS)  state_next_s = ST_HALTED;
            else                             state_next_s = ST_FETCH;
         end
         ST_HALTED: state_next_s = ST_HALTED;
         default:   state_next_s = ST_FETCH;
      endcase
   end

   // Control state, pc/npc, instruction latch and registered bus requests
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= ST_FETCH;
         pc_r             <= RESET_VECTOR;
         npc_r            <= RESET_VECTOR + 32'd4;
         ir_r             <= 32'd0;
         data_address_r   <= 32'd0;
         data_writedata_r <= 32'd0;
         instr_read_r     <= 1'b1;
         data_read_r      <= 1'b0;
         data_write_r     <= 1'b0;
         active_r         <= 1'b1;
      end else begin
         state_r <= state_next_s;
         if (state_r == ST_FETCH && !instr_waitrequest) ir_r <= instr_readdata;
         if (advance_s) begin
            pc_r  <= npc_r;
            npc_r <= npc_next_s;
         end
         if (state_r == ST_EXEC && is_mem_s) begin
            data_address_r   <= rs_val_s + sext_s;
            data_writedata_r <= rt_val_s;
         end
         instr_read_r <= (state_next_s == ST_FETCH);
         data_read_r  <= (state_next_s == ST_MEM) && is_load_s;
         data_write_r <= (state_next_s == ST_MEM) && is_store_s;
         active_r     <= (state_next_s != ST_HALTED);
      end
   end

   // Register file; $0 is never written so it always reads zero
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
      end else if (rf_we_s && rf_waddr_s != 5'd0) begin
         regs_r[rf_waddr_s] <= rf_wdata_s;
      end
   end

   assign instr_address  = pc_r;
   assign instr_read     = instr_read_r;
   assign data_address   = data_address_r;
   assign data_read      = data_read_r;
   assign data_write     = data_write_r;
   assign data_writedata = data_writedata_r;
   assign active         = active_r;
   assign register_v0    = regs_r[2];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: an instruction-level ISA model plus bus
// responders with random waitstates; directed programs pin the model.
module tb_mips_multicycle_core;

   localparam logic [31:0] RV = 32'hBFC00000;
   localparam logic [31:0] HA = 32'h00000000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr_address, instr_readdata = 32'd0;
   logic        instr_read, instr_waitrequest = 1'b0;
   logic [31:0] data_address, data_writedata, data_readdata = 32'd0;
   logic        data_read, data_write, data_waitrequest = 1'b0;
   logic        active;
   logic [31:0] register_v0;

   mips_multicycle_core #(.RESET_VECTOR(RV), .HALT_ADDRESS(HA)) dut (
      .clk(clk), .reset(reset),
      .instr_address(instr_address), .instr_read(instr_read),
      .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
      .data_address(data_address), .data_read(data_read), .data_write(data_write),
      .data_writedata(data_writedata), .data_readdata(data_readdata),
      .data_waitrequest(data_waitrequest),
      .active(active), .register_v0(register_v0)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog [0:63];
   int          prog_len = 0;
   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] mdl_mem [logic [31:0]];

   logic [31:0] mregs [0:31];
   logic [31:0] mpc, mnpc;
   bit          mhalted, inflight, cur_load, cur_store;
   logic [31:0] cur_addr, cur_wdata;
   int          k, active_cycles;
   bit          zero_waits, force_dstall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] imem(input logic [31:0] a);
      logic [31:0] off;
      off = a - RV;
      if (a[1:0] == 2'b00 && off < 32'(prog_len * 4)) return prog[off[7:2]];
      return 32'h00000008;   // JR $0 outside the program: runs off to halt
   endfunction

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
   endfunction

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : mem_init(a);
   endfunction

   function automatic logic [31:0] mdl_rd(input logic [31:0] a);
      return mdl_mem.exists(a) ? mdl_mem[a] : mem_init(a);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mpc = RV; mnpc = RV + 32'd4; mhalted = 1'b0; inflight = 1'b0; k = 0;
      cur_load = 1'b0; cur_store = 1'b0;
   endtask

   task automatic setr(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) mregs[r] = v;
   endtask

   // One whole instruction at architectural level
   task automatic model_step(input logic [31:0] ins);
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, se, ze, p4, nn;
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      a = mregs[rs]; b = mregs[rt];
      se = {{16{ins[15]}}, ins[15:0]}; ze = {16'd0, ins[15:0]};
      p4 = mpc + 32'd4; nn = mnpc + 32'd4;
      cur_load = 1'b0; cur_store = 1'b0; cur_addr = a + se; cur_wdata = b;
      case (ins[31:26])
         6'h00: case (ins[5:0])
            6'h21: setr(rd, a + b);
            6'h23: setr(rd, a - b);
            6'h24: setr(rd, a & b);
            6'h25: setr(rd, a | b);
            6'h26: setr(rd, a ^ b);
            6'h2A: setr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            6'h2B: setr(rd, (a < b) ? 32'd1 : 32'd0);
            6'h08: nn = a;
            default: ;
         endcase
         6'h02: nn = {p4[31:28], ins[25:0], 2'b00};
         6'h03: begin nn = {p4[31:28], ins[25:0], 2'b00}; setr(5'd31, mpc + 32'd8); end
         6'h04: if (a == b) nn = p4 + (se << 2);
         6'h05: if (a != b) nn = p4 + (se << 2);
         6'h09: setr(rt, a + se);
         6'h0C: setr(rt, a & ze);
         6'h0D: setr(rt, a | ze);
         6'h0E: setr(rt, a ^ ze);
         6'h0F: setr(rt, {ins[15:0], 16'd0});
         6'h23: begin cur_load = 1'b1; setr(rt, mdl_rd(cur_addr)); end
         6'h2B: begin cur_store = 1'b1; mdl_mem[cur_addr] = b; end
         default: ;
      endcase
      mpc = mnpc; mnpc = nn; mhalted = (mpc == HA);
   endtask

   // Compare DUT outputs with what the model says this cycle must show
   task automatic check_cycle();
      if (active) active_cycles++;
      if (!inflight) begin
         if (mhalted) begin
            chk("active_halted", 32'(active), 32'd0);
            chk("fetch_halted", 32'(instr_read), 32'd0);
            chk("dreq_halted", {30'd0, data_read, data_write}, 32'd0);
         end else begin
            chk("active", 32'(active), 32'd1);
            chk("instr_read", 32'(instr_read), 32'd1);
            chk("instr_address", instr_address, mpc);
            chk("dreq_fetch", {30'd0, data_read, data_write}, 32'd0);
         end
         chk("register_v0", register_v0, mregs[2]);
      end else begin
         chk("active_busy", 32'(active), 32'd1);
         chk("instr_read_busy", 32'(instr_read), 32'd0);
         if (k == 0) begin
            chk("dreq_exec", {30'd0, data_read, data_write}, 32'd0);
         end else begin
            chk("data_read", 32'(data_read), 32'(cur_load));
            chk("data_write", 32'(data_write), 32'(cur_store));
            chk("data_address", data_address, cur_addr);
            if (cur_store) chk("data_writedata", data_writedata, cur_wdata);
         end
      end
   endtask

   // Choose waitstates/read data for the coming edge and advance the model
   task automatic drive_cycle();
      bit w;
      instr_waitrequest = ($urandom_range(0, 1) == 1);
      data_waitrequest  = ($urandom_range(0, 1) == 1);
      instr_readdata    = $urandom();
      data_readdata     = $urandom();
      if (!inflight) begin
         if (!mhalted) begin
            w = zero_waits ? 1'b0 : ($urandom_range(0, 2) == 0);
            instr_waitrequest = w;
            if (!w) begin
               instr_readdata = imem(mpc);
               model_step(instr_readdata);
               inflight = 1'b1;
               k = 0;
            end
         end
      end else if (k == 0) begin
         if (!(cur_load || cur_store)) inflight = 1'b0;
         k = 1;
      end else begin
         w = force_dstall ? 1'b1 : (zero_waits ? 1'b0 : ($urandom_range(0, 2) == 0));
         data_waitrequest = w;
         if (!w) begin
            if (cur_load) data_readdata = bus_rd(data_address);
            if (cur_store) bus_mem[data_address] = data_writedata;
            inflight = 1'b0;
         end
         k++;
      end
   endtask

   task automatic run(input int budget);
      int n, hs;
      n = 0; hs = 0;
      while (n < budget && hs < 3) begin
         check_cycle();
         if (mhalted && !inflight) hs++;
         drive_cycle();
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      instr_waitrequest = ($urandom_range(0, 1) == 1);
      data_waitrequest  = ($urandom_range(0, 1) == 1);
      instr_readdata    = $urandom();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      active_cycles = 0;
      chk("rst_data_read", 32'(data_read), 32'd0);
      chk("rst_data_write", 32'(data_write), 32'd0);
      chk("rst_data_address", data_address, 32'd0);
      chk("rst_data_writedata", data_writedata, 32'd0);
   endtask

   task automatic load_p1();
      prog[0] = 32'h24020005;   // ADDIU $2,$0,5
      prog[1] = 32'h00421021;   // ADDU  $2,$2,$2
      prog[2] = 32'h00000008;   // JR    $0
      prog[3] = 32'h00000000;   // NOP (delay slot)
      prog_len = 4;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  fn, op;
      int          s, off;
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom());
      s = int'($urandom_range(0, 19));
      if (s < 6) begin
         case ($urandom_range(0, 6))
            0: fn = 6'h21; 1: fn = 6'h23; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h26; 5: fn = 6'h2A; default: fn = 6'h2B;
         endcase
         return {6'h00, rs, rt, rd, 5'd0, fn};
      end else if (s < 10) begin
         case ($urandom_range(0, 4))
            0: op = 6'h09; 1: op = 6'h0C; 2: op = 6'h0D; 3: op = 6'h0E; default: op = 6'h0F;
         endcase
         return {op, rs, rt, imm};
      end else if (s < 14) begin
         imm = 16'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 3) != 0) rs = 5'd0;
         return {($urandom_range(0, 1) == 1) ? 6'h23 : 6'h2B, rs, rt, imm};
      end else if (s < 16) begin
         off = int'($urandom_range(0, 12)) - 4;
         return {($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05, rs & 5'd3, rt & 5'd3, 16'(off)};
      end else if (s < 17) begin
         return {($urandom_range(0, 1) == 1) ? 6'h02 : 6'h03, 26'((RV >> 2) + 32'($urandom_range(0, 52)))};
      end else if (s < 18) begin
         if ($urandom_range(0, 1) == 1) rs = 5'd31;
         return {6'h00, rs, 15'd0, 6'h08};
      end else begin
         return $urandom();
      end
   endfunction

   initial begin
      zero_waits = 1'b1; force_dstall = 1'b0;
      model_reset();
      @(negedge clk);

      // Straight-line ALU program, zero waits: 4 instructions x 2 cycles
      load_p1();
      do_reset();
      run(60);
      chk("p1_model_v0", mregs[2], 32'd10);
      chk("p1_dut_v0", register_v0, 32'd10);
      chk("p1_cycles", 32'(active_cycles), 32'd8);

      // Jumps, branches and delay slots under random waits
      prog[0]  = 32'h0FF00006;  // JAL idx6
      prog[1]  = 32'h24020001;  // ADDIU $2,$0,1
      prog[2]  = 32'h34420100;  // ORI $2,$2,0x100 (return point)
      prog[3]  = 32'h00000008;  // JR $0
      prog[4]  = 32'h24421000;  // ADDIU $2,$2,0x1000
      prog[5]  = 32'h00000000;
      prog[6]  = 32'h10000002;  // BEQ $0,$0,+2 -> idx9
      prog[7]  = 32'h24420002;
      prog[8]  = 32'h24420040;  // skipped
      prog[9]  = 32'h14000005;  // BNE $0,$0 not taken
      prog[10] = 32'h24420004;
      prog[11] = 32'h03E00008;  // JR $31
      prog[12] = 32'h24420008;
      prog_len = 13;
      zero_waits = 1'b0;
      do_reset();
      run(400);
      chk("p2_model_v0", mregs[2], 32'h0000110F);
      chk("p2_dut_v0", register_v0, 32'h0000110F);
      chk("p2_model_ra", mregs[31], 32'hBFC00008);

      // Store then loads, zero waits: 19 cycles in total
      prog[0] = 32'h3C02DEAD;   // LUI $2,0xDEAD
      prog[1] = 32'h3442BEEF;   // ORI $2,$2,0xBEEF
      prog[2] = 32'hAC020004;   // SW  $2,4($0)
      prog[3] = 32'h8C030004;   // LW  $3,4($0)
      prog[4] = 32'h8C020000;   // LW  $2,0($0)
      prog[5] = 32'h00431021;   // ADDU $2,$2,$3
      prog[6] = 32'h00000008;   // JR $0
      prog[7] = 32'h00000000;
      prog_len = 8;
      bus_mem[32'd0] = 32'h12345678;
      mdl_mem[32'd0] = 32'h12345678;
      zero_waits = 1'b1;
      do_reset();
      run(80);
      chk("p3_model_v0", mregs[2], 32'hF0E21567);
      chk("p3_dut_v0", register_v0, 32'hF0E21567);
      chk("p3_bus_word4", bus_rd(32'd4), 32'hDEADBEEF);
      chk("p3_cycles", 32'(active_cycles), 32'd19);

      // LW stalled forever, then reset in the middle of the stall
      prog[0] = 32'h8C020000;
      prog_len = 1;
      force_dstall = 1'b1;
      do_reset();
      run(8);
      chk("stall_data_read", 32'(data_read), 32'd1);
      force_dstall = 1'b0;
      load_p1();
      do_reset();
      run(60);
      chk("post_abort_v0", register_v0, 32'd10);

      // Random programs, each cut off by reset after a random budget
      zero_waits = 1'b0;
      for (int p = 0; p < 25; p++) begin
         prog_len = 48;
         for (int i = 0; i < 48; i++) prog[i] = rand_instr();
         do_reset();
         run(int'($urandom_range(30, 400)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle MIPS-I integer core, successor to the single-cycle five-instruction CPU. It has a parametrised reset vector and halt address, and a broader instruction subset with branch delay slots. Instruction and data ports use a waitrequest handshake, so the core can sit behind slow or arbitrated memory. It exposes `active` and a `register_v0` debug output for the testbench harness.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000: PC loaded on reset.
- `HALT_ADDRESS`, default 32'h00000000: fetching from this PC halts the core.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_address` out 32: fetch address (current PC).
- `instr_read` out 1: fetch request.
- `instr_readdata` in 32: fetched word; valid when `instr_read` is high and `instr_waitrequest` is low.
- `instr_waitrequest` in 1: stall the fetch while high.
- `data_address` out 32: load/store address, base register + sign-extended imm16.
- `data_read` out 1: load request.
- `data_write` out 1: store request.
- `data_writedata` out 32: store data, value of rt.
- `data_readdata` in 32: load data; valid when `data_read` is high and `data_waitrequest` is low.
- `data_waitrequest` in 1: stall the data access while high.
- `active` out 1: high from reset until halt.
- `register_v0` out 32: current value of $2.

## Operation
- Register file: 32x32. $0 reads 0; writes to $0 are discarded.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, JR.
  - I-type: ADDIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
  - Any other encoding executes as NOP.
- Immediate extension:
  - ADDIU, LW, SW, BEQ, BNE: sign-extend imm16.
  - ANDI, ORI, XORI: zero-extend imm16.
  - LUI: rt = imm16 << 16.
- Arithmetic is 32-bit modulo with no overflow traps.
- Comparisons: SLT is signed, SLTU is unsigned; the result is 0 or 1.
- Destination register: rd for R-type; rt for I-type; $31 for JAL.
- Branch and jump targets:
  - BEQ/BNE: PC+4 + (sext(imm16) << 2).
  - J/JAL: {PC+4[31:28], imm26, 2'b00}.
  - JR: rs.
  - JAL writes PC+8 to $31.
- Delay slot: every branch and jump has one delay slot. The core holds `pc` and `npc`.
  - After any instruction: pc <= npc.
  - npc <= target if taken, otherwise npc+4.
- States:
  - FETCH: `instr_read` = 1. Stay while `instr_waitrequest` is high; otherwise latch the instruction and go to EXEC.
  - EXEC: decode, compute, resolve the branch, and write back ALU/JAL results.
    - LW/SW go to MEM.
    - All other instructions advance the PC and go to FETCH, or to HALTED if the new pc equals HALT_ADDRESS.
  - MEM: assert exactly one of `data_read`/`data_write`, holding address and data constant. Stay while `data_waitrequest` is high.
    - On completion, LW writes rt from `data_readdata`.
    - Then advance the PC; go to FETCH or HALTED by the same rule as EXEC.
  - HALTED: `active` = 0. All requests are low; nothing is fetched; the register file is frozen. Only reset exits this state.
- Halt check: applied after the PC update, so the delay-slot instruction of `JR $0` executes before the halt.

## Timing
- Reset, synchronous and overriding all other inputs on the same edge:
  - State goes to FETCH.
  - pc = RESET_VECTOR, npc = RESET_VECTOR+4.
  - All registers = 0.
  - Outputs after the edge: `active` = 1; `instr_read` = 1 in FETCH; `data_read` = `data_write` = 0; `data_address` = 0; `data_writedata` = 0; `register_v0` = 0.
  - Reset asserted mid-MEM drops `data_read`/`data_write` on the next edge. An aborted LW does not write its register.
- Requests are registered-state decoded and glitch-free. A request and its address stay stable until the cycle where waitrequest is sampled low.
- Latency with zero wait states:
  - ALU, branch, jump: 2 cycles (FETCH+EXEC).
  - LW/SW: 3 cycles. Each waitrequest-high cycle adds one cycle.
- Register-write visibility: a write made in EXEC or MEM is visible to the next instruction's EXEC. No forwarding is needed in a multi-cycle design.
- `register_v0` reflects the write on the cycle after the writing edge.
- Back-to-back branch in a delay slot: behaviour is architecturally undefined, but the core must not lock up; it follows the pc/npc rule literally.

## Test plan
- ADDIU $2,$0,5 then ADDU $2,$2,$2 from RESET_VECTOR, zero waits → `register_v0` = 5 after cycle 2, then 10 after cycle 4; `instr_address` steps BFC00000 → BFC00004 → BFC00008.
- SW $2,4($0) with $2 = 0xDEADBEEF, `data_waitrequest` high for 3 cycles → `data_write`, `data_address` = 4 and `data_writedata` = DEADBEEF held for 4 cycles, deasserted afterwards; total 6 cycles.
- LW $2,0($0) with readdata 0x12345678, `instr_waitrequest` high for 2 cycles on fetch → `register_v0` = 12345678 after 5 cycles.
- BEQ $0,$0,+2 followed by ADDIU $2,$0,1 → delay-slot ADDIU executes (`register_v0` = 1); next fetch is at branch PC+12. BNE $0,$0 is not taken and falls through to PC+8.
- JAL then JR $31: $31 = JAL PC+8; JR returns there.
- JR $0 followed by ORI $2,$0,7 → `register_v0` = 7 and `active` falls once pc = 0; no further fetch.
- Reset asserted during a MEM stall → `data_read` low the next cycle; the LW target is unchanged; fetch restarts at RESET_VECTOR.
